rtc_field_seq_loader: RTL and testbench

//  Sequencer that transfers NUM_FIELDS time/date fields (sec, min, hour, day, month,

---
 rtl/rtc_field_seq_loader.sv | 123 ++++++++++++
 tb/tb_rtc_field_seq_loader.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/rtc_field_seq_loader.sv
// rtc_field_seq_loader: snapshots NUM_FIELDS RTC fields and writes them to the register bank over req/ack.
// Optional FIELD_BCD_CHECK_EN skips fields holding a non-BCD nibble and raises sticky bcd_err.
module rtc_field_seq_loader #(
   parameter int DATA_W     = 8,
   parameter int NUM_FIELDS = 9,
   parameter int ADDR_W     = 4,
   parameter int ADDR_BASE  = 0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic                         abort,
   input  logic [NUM_FIELDS*DATA_W-1:0] fields_in,
   input  logic                         wr_ack,
   output logic                         wr_en,
   output logic [ADDR_W-1:0]            wr_addr,
   output logic [DATA_W-1:0]            wr_data,
   output logic                         busy,
   output logic                         done,
   output logic                         bcd_err
);
   localparam int IDX_W = NUM_FIELDS > 1 ? $clog2(NUM_FIELDS) : 1;
   localparam logic [ADDR_W-1:0] BASE = ADDR_W'(ADDR_BASE);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_FIELDS - 1);
   typedef enum logic [1:0] {IDLE, SNAP, WRITE, DONE} state_t;
   state_t state, state_n;
   logic [IDX_W-1:0] idx, idx_n, nxt_idx;
   logic [NUM_FIELDS*DATA_W-1:0] snap, snap_n, src;
   logic [DATA_W-1:0] nxt_data, wr_data_n;
   logic [ADDR_W-1:0] wr_addr_n;
   logic wr_en_n, busy_n, done_n, bcd_err_n, nxt_bad;
`ifdef FIELD_BCD_CHECK_EN
   function automatic logic bad_bcd(input logic [DATA_W-1:0] v);
      bad_bcd = 1'b0;
      for (int i = 0; i < DATA_W / 4; i++) bad_bcd |= (v[i*4 +: 4] > 4'd9);
   endfunction
   assign nxt_bad = bad_bcd(nxt_data);
`else
   assign nxt_bad = 1'b0;
`endif
   // The field presented next comes straight from fields_in while snapshotting, so the first write is not delayed.
   assign src      = state == SNAP ? fields_in : snap;
   assign nxt_idx  = (state == SNAP || idx == LAST) ? '0 : idx + IDX_W'(1);
   assign nxt_data = src[nxt_idx*DATA_W +: DATA_W];
   always_comb begin
      state_n   = state;
      idx_n     = idx;
      snap_n    = snap;
      wr_en_n   = 1'b0;
      wr_addr_n = wr_addr;
      wr_data_n = wr_data;
      busy_n    = 1'b0;
      done_n    = 1'b0;
      bcd_err_n = bcd_err;
      case (state)
         IDLE: begin
            state_n = start ? SNAP : IDLE;
            busy_n  = start;
         end
         SNAP: begin
            state_n   = WRITE;
            snap_n    = fields_in;
            idx_n     = '0;
            bcd_err_n = 1'b0;
            busy_n    = 1'b1;
            wr_en_n   = !nxt_bad;
            wr_addr_n = BASE + ADDR_W'(nxt_idx);
            wr_data_n = nxt_data;
         end
         WRITE: begin
            busy_n    = 1'b1;
            wr_en_n   = wr_en;
            bcd_err_n = bcd_err | !wr_en;
            // wr_en low in WRITE marks a skipped field: advance without waiting for an ack
            if (wr_ack || !wr_en) begin
               if (idx == LAST) begin
                  state_n = DONE;
                  idx_n   = '0;
                  busy_n  = 1'b0;
                  done_n  = 1'b1;
                  wr_en_n = 1'b0;
               end else begin
                  idx_n     = nxt_idx;
                  wr_en_n   = !nxt_bad;
                  wr_addr_n = BASE + ADDR_W'(nxt_idx);
                  wr_data_n = nxt_data;
               end
            end
         end
         default: state_n = IDLE;
      endcase
      if (abort) begin
         state_n = IDLE;
         idx_n   = '0;
         wr_en_n = 1'b0;
         busy_n  = 1'b0;
         done_n  = 1'b0;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         idx     <= '0;
         snap    <= '0;
         wr_en   <= 1'b0;
         wr_addr <= BASE;
         wr_data <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         bcd_err <= 1'b0;
      end else begin
         state   <= state_n;
         idx     <= idx_n;
         snap    <= snap_n;
         wr_en   <= wr_en_n;
         wr_addr <= wr_addr_n;
         wr_data <= wr_data_n;
         busy    <= busy_n;
         done    <= done_n;
         bcd_err <= bcd_err_n;
      end
   end
endmodule

// File: tb/tb_rtc_field_seq_loader.sv
// tb_rtc_field_seq_loader: directed and randomized sequences checked against a field-list model;
// a second instance with ADDR_BASE=12 exercises address wrap. Honours FIELD_BCD_CHECK_EN.
module tb_rtc_field_seq_loader;
   localparam int DW = 8, NF = 9, AW = 4, BASE_W = 12;
`ifdef FIELD_BCD_CHECK_EN
   localparam bit BCD_EN = 1'b1;
`else
   localparam bit BCD_EN = 1'b0;
`endif
   logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, abort = 1'b0, wr_ack = 1'b0;
   logic [NF*DW-1:0] fields_in = '0;
   logic wr_en, busy, done, bcd_err, wr_en_w, busy_w, done_w, bcd_err_w;
   logic [AW-1:0] wr_addr, wr_addr_w;
   logic [DW-1:0] wr_data, wr_data_w;
   int n_assert = 0, n_fail = 0;
   always #5 clk = ~clk;
   rtc_field_seq_loader #(.DATA_W(DW), .NUM_FIELDS(NF), .ADDR_W(AW), .ADDR_BASE(0)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .fields_in(fields_in), .wr_ack(wr_ack),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done), .bcd_err(bcd_err));
   rtc_field_seq_loader #(.DATA_W(DW), .NUM_FIELDS(NF), .ADDR_W(AW), .ADDR_BASE(BASE_W)) dut_w (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .fields_in(fields_in), .wr_ack(wr_ack),
      .wr_en(wr_en_w), .wr_addr(wr_addr_w), .wr_data(wr_data_w), .busy(busy_w), .done(done_w), .bcd_err(bcd_err_w));
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   function automatic bit bcd_ok(input logic [DW-1:0] v);
      return v[3:0] <= 4'd9 && v[7:4] <= 4'd9;
   endfunction
   function automatic logic [NF*DW-1:0] rnd_fields(input bit bcd_only);
      logic [NF*DW-1:0] f;
      for (int i = 0; i < NF; i++)
         f[i*DW +: DW] = bcd_only ? {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))} : 8'($urandom);
      return f;
   endfunction
   function automatic logic [NF*DW-1:0] ramp_fields();
      logic [NF*DW-1:0] f;
      for (int i = 0; i < NF; i++) f[i*DW +: DW] = 8'(i);
      return f;
   endfunction
   task automatic check_reset(input string tag);
      check({tag, "_wr_en"}, {wr_en, wr_en_w}, 0);
      check({tag, "_addr"}, wr_addr, 0);
      check({tag, "_addr_w"}, wr_addr_w, BASE_W);
      check({tag, "_data"}, {wr_data, wr_data_w}, 0);
      check({tag, "_busy"}, {busy, busy_w}, 0);
      check({tag, "_done"}, {done, done_w}, 0);
      check({tag, "_bcd_err"}, {bcd_err, bcd_err_w}, 0);
   endtask
   // mode 0: ack tied high, 1: ack after 3 waiting cycles, 2: random 0..3 cycle delay per write
   task automatic run_seq(input int mode, input int abort_at, input bit chk_first);
      logic [DW-1:0] snap_m [NF];
      int exp_idx[$];
      logic [DW-1:0] exp_dat[$];
      logic [AW-1:0] h_addr;
      logic [DW-1:0] h_data;
      bit pend, aborted, exp_err;
      int busy_n, done_at, first_wr, wait_c, dly, nwr, idle_done;
      exp_err = 1'b0;
      for (int i = 0; i < NF; i++) begin
         snap_m[i] = fields_in[i*DW +: DW];
         if (!BCD_EN || bcd_ok(snap_m[i])) begin
            exp_idx.push_back(i);
            exp_dat.push_back(snap_m[i]);
         end else exp_err = 1'b1;
      end
      busy_n = 0; done_at = 0; first_wr = 0; wait_c = 0; nwr = 0; pend = 1'b0; aborted = 1'b0;
      h_addr = '0; h_data = '0;
      dly = mode == 1 ? 3 : mode == 2 ? int'($urandom_range(0, 3)) : 0;
      start = 1'b1;
      wr_ack = mode == 0;
      for (int n = 1; n <= 80 && done_at == 0 && !aborted; n++) begin
         @(negedge clk);
         start = 1'b0;
         if (n == 2) fields_in = rnd_fields(1'b0);
         if (abort) begin
            check("abort_wr_en", wr_en, 0);
            check("abort_busy", busy, 0);
            check("abort_done", done, 0);
            abort = 1'b0;
            aborted = 1'b1;
         end else begin
            if (busy) busy_n++;
            if (done) done_at = n;
            if (pend) begin
               check("hold_en", wr_en, 1);
               check("hold_addr", wr_addr, h_addr);
               check("hold_data", wr_data, h_data);
            end
            if (wr_en) begin
               if (first_wr == 0) first_wr = n;
               h_addr = wr_addr;
               h_data = wr_data;
               if (mode == 0 || wait_c >= dly) begin
                  if (nwr < exp_idx.size()) begin
                     check("wr_addr", wr_addr, exp_idx[nwr] % 16);
                     check("wr_addr_wrap", wr_addr_w, (exp_idx[nwr] + BASE_W) % 16);
                     check("wr_data", wr_data, exp_dat[nwr]);
                     check("wr_data_w", wr_data_w, exp_dat[nwr]);
                  end else check("extra_write", nwr, exp_idx.size());
                  if (abort_at == nwr) abort = 1'b1;
                  nwr++;
                  wait_c = 0;
                  pend = 1'b0;
                  wr_ack = 1'b1;
                  if (mode == 2) dly = $urandom_range(0, 3);
               end else begin
                  wait_c++;
                  pend = 1'b1;
                  wr_ack = 1'b0;
               end
            end else wr_ack = mode == 0;
         end
      end
      if (aborted) begin
         idle_done = 0;
         repeat (15) begin
            @(negedge clk);
            if (done || busy || wr_en) idle_done++;
         end
         check("idle_after_abort", idle_done, 0);
      end else begin
         check("done_seen", done_at != 0, 1);
         check("done_w", done_w, 1);
         check("done_wr_en", {wr_en, wr_en_w}, 0);
         check("done_busy", {busy, busy_w}, 0);
         check("write_count", nwr, exp_idx.size());
         check("bcd_err", bcd_err, exp_err);
         check("bcd_err_w", bcd_err_w, exp_err);
         if (mode == 0) begin
            check("done_latency", done_at, NF + 2);
            check("busy_cycles", busy_n, NF + 1);
         end
         if (chk_first) check("first_wr_latency", first_wr, 2);
         @(negedge clk);
         check("done_pulse", done, 0);
      end
   endtask
   initial begin
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check_reset("reset");
      rst_n = 1'b1;
      @(negedge clk);
      fields_in = ramp_fields();
      run_seq(0, -1, 1);
      fields_in = rnd_fields(1'b1);
      run_seq(1, -1, 0);
      fields_in = rnd_fields(1'b1);
      fields_in[DW-1:0] = 8'h59;
      run_seq(2, -1, 0);
      fields_in = ramp_fields();
      run_seq(0, 3, 0);
      fields_in = ramp_fields();
      run_seq(0, -1, 1);
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      check("start_abort_busy", busy, 0);
      @(negedge clk);
      check("start_abort_idle", {busy, wr_en, done}, 0);
      fields_in = rnd_fields(1'b1);
      fields_in[4*DW +: DW] = 8'h1A;
      run_seq(0, -1, 0);
      fields_in = rnd_fields(1'b1);
      run_seq(2, -1, 0);
      repeat (8) begin
         fields_in = rnd_fields(1'($urandom_range(0, 1)));
         run_seq(int'($urandom_range(0, 2)), -1, 0);
      end
      fields_in = rnd_fields(1'b1);
      run_seq(2, int'($urandom_range(0, 3)), 0);
      fields_in = ramp_fields();
      wr_ack = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("pre_reset_wr_en", wr_en, 1);
      #1 rst_n = 1'b0;
      #1 check_reset("async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      fields_in = ramp_fields();
      run_seq(0, -1, 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
